// File: rtl/modulador_fm0.sv
// FM0 (bi-phase space) baseband transmitter: 16-bit payload, LSB first, on the 8-bit sinal DAC bus.
// Define MODULADOR_PREAMBLE_EN to send the PREAMBLE byte ahead of the payload.
module modulador_fm0 #(
   parameter int unsigned BIT_LEN  = 32,
   parameter logic [7:0]  PREAMBLE = 8'hB4,
   parameter logic [7:0]  HIGH_LVL = 8'hE0,
   parameter logic [7:0]  LOW_LVL  = 8'h20,
   parameter logic [7:0]  IDLE_LVL = 8'h80
) (
   input  logic       G_CLK_TX,
   input  logic       reset,
   input  logic [7:0] DATA_BYTE_0,
   input  logic [7:0] DATA_BYTE_1,
   input  logic       TXENABLE,
   input  logic       INTMASK,
   input  logic       int_clr,
   output logic [7:0] sinal,
   output logic       STATUS,
   output logic       INTFLAG,
   output logic       int_tx_host
);

   localparam int unsigned   CW       = $clog2(BIT_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_LEN - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(BIT_LEN / 2 - 1);

`ifdef MODULADOR_PREAMBLE_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2, S_TAIL = 2'd3} state_t;
   localparam state_t S_FIRST = S_PRE;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd2, S_TAIL = 2'd3} state_t;
   localparam state_t S_FIRST = S_DATA;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   shreg_q, shreg_d;
   logic          level_q, level_d;
   logic          txen_q;
   logic          flag_q, flag_d;
   logic          int_q;

   logic start, cell_end, mid, cur_bit, set_flag;

   assign start    = (state_q == S_IDLE) && TXENABLE && !txen_q;
   assign cell_end = (cnt_q == CNT_LAST);
   assign mid      = (cnt_q == CNT_MID);

`ifdef MODULADOR_PREAMBLE_EN
   assign cur_bit = (state_q == S_PRE) ? PREAMBLE[bit_q[2:0]] : shreg_q[0];
`else
   logic unused_pre;
   assign unused_pre = ^PREAMBLE;
   assign cur_bit    = shreg_q[0];
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      level_d  = level_q;
      set_flag = 1'b0;
      if (state_q == S_IDLE) begin
         if (start) begin
            // level is cleared and then inverted for the first cell start: frames open high
            shreg_d = {DATA_BYTE_1, DATA_BYTE_0};
            level_d = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_FIRST;
         end
      end else if (!TXENABLE) begin
         state_d = S_IDLE;
         level_d = 1'b0;
         cnt_d   = '0;
         bit_d   = '0;
      end else begin
         cnt_d = cell_end ? '0 : cnt_q + 1'b1;
         if (mid && !cur_bit && state_q != S_TAIL)
            level_d = ~level_q;
         if (cell_end) begin
            level_d = ~level_q;
            bit_d   = bit_q + 4'd1;
            case (state_q)
`ifdef MODULADOR_PREAMBLE_EN
               S_PRE: begin
                  if (bit_q == 4'd7) begin
                     state_d = S_DATA;
                     bit_d   = '0;
                  end
               end
`endif
               S_DATA: begin
                  shreg_d = {1'b0, shreg_q[15:1]};
                  if (bit_q == 4'd15) begin
                     state_d = S_TAIL;
                     bit_d   = '0;
                  end
               end
               default: begin
                  state_d  = S_IDLE;
                  level_d  = 1'b0;
                  bit_d    = '0;
                  set_flag = 1'b1;
               end
            endcase
         end
      end
   end

   // completion set has priority over a simultaneous host clear
   assign flag_d = set_flag | (flag_q & ~int_clr);

   always_ff @(posedge G_CLK_TX or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         level_q <= 1'b0;
         txen_q  <= 1'b1;
         flag_q  <= 1'b0;
         int_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         level_q <= level_d;
         txen_q  <= TXENABLE;
         flag_q  <= flag_d;
         int_q   <= flag_q & INTMASK;
      end
   end

   assign sinal       = (state_q == S_IDLE) ? IDLE_LVL : (level_q ? HIGH_LVL : LOW_LVL);
   assign STATUS      = (state_q != S_IDLE);
   assign INTFLAG     = flag_q;
   assign int_tx_host = int_q;

endmodule

// File: doc/modulador_fm0.md
# modulador_fm0

- Baseband FM0 (bi-phase space) transmitter; the transmit-side counterpart of the board's edge-timing demodulator.
- Latches a 16-bit payload from `DATA_BYTE_0`/`DATA_BYTE_1` and serialises it as FM0 bit cells on the 8-bit `sinal` level bus feeding the DAC.
- Reports busy, completion flag and a maskable host interrupt.
- Bit timing matches the receiver's threshold of 24 clocks: a full cell is 32 clocks and a half cell is 16 clocks.

## Interface
Parameters:
- `BIT_LEN`, 32: clocks per bit cell; must be even and ≥4. Half cell = `BIT_LEN/2`.
- `PREAMBLE`, 8'hB4: preamble byte, sent LSB first (only with the macro).
- `HIGH_LVL`, 8'hE0: `sinal` code for the high level.
- `LOW_LVL`, 8'h20: `sinal` code for the low level.
- `IDLE_LVL`, 8'h80: `sinal` code when not transmitting.

Ports:
- `G_CLK_TX` in 1: transmit clock.
- `reset` in 1: asynchronous, active-low reset.
- `DATA_BYTE_0` in 8: first payload byte, sent LSB first.
- `DATA_BYTE_1` in 8: second payload byte, sent LSB first.
- `TXENABLE` in 1: a rising edge starts a frame; a low level aborts the frame.
- `INTMASK` in 1: 1 = interrupt enabled.
- `int_clr` in 1: single-cycle pulse that clears `INTFLAG`.
- `sinal` out 8: line level.
- `STATUS` out 1: busy.
- `INTFLAG` out 1: frame-complete flag, sticky.
- `int_tx_host` out 1: registered `INTFLAG & INTMASK`.

## Operation
- FSM states: IDLE, PRE (macro only), DATA, TAIL.
- IDLE:
  - `sinal`=`IDLE_LVL`, `STATUS`=0.
  - A rising edge of `TXENABLE` (current 1, previous sample 0) does the following:
    - latches {`DATA_BYTE_1`,`DATA_BYTE_0`} into a 16-bit shift register;
    - clears internal `level` to 0;
    - enters PRE, or DATA when the macro is absent.
- Encoding, per bit cell:
  - At cell start, `level` inverts.
  - If the bit is 0, `level` inverts again at the half-cell point (cycle `BIT_LEN/2` of the cell).
  - A 1 bit has no mid-cell transition.
  - `sinal` = `level` ? `HIGH_LVL` : `LOW_LVL` while in PRE, DATA or TAIL.
  - The first cell of every frame therefore starts high.
- Cell counter:
  - Width `$clog2(BIT_LEN)`; runs 0..`BIT_LEN`-1, then wraps to 0.
  - Each wrap advances the bit index.
- PRE: 8 cells carrying `PREAMBLE[0]`..`PREAMBLE[7]`, then DATA.
- DATA: 16 cells, bits 0..15 of the shift register (`DATA_BYTE_0` bit 0 first), then TAIL.
- TAIL:
  - One cell with a start-of-cell inversion and no mid-cell inversion (a trailing 1), so the receiver sees a final edge.
  - Then return to IDLE, `sinal`=`IDLE_LVL`.
  - Set `INTFLAG` in the same cycle as the return to IDLE.
- `STATUS`=1 in every state except IDLE.
- Abort: `TXENABLE`=0 in any non-IDLE state sends the FSM to IDLE on the next edge. `sinal`=`IDLE_LVL`; `INTFLAG` is not set.
- A rising edge of `TXENABLE` while busy cannot occur, because a deassert aborts the frame first. Input data changes while busy are ignored.
- `INTFLAG`:
  - Set by frame completion.
  - Cleared by `int_clr`.
  - If set and clear occur in the same cycle, set wins.
- `int_tx_host` follows `INTFLAG & INTMASK` with one-cycle latency.

## Timing
- Reset values: `sinal`=`IDLE_LVL`, `STATUS`=0, `INTFLAG`=0, `int_tx_host`=0, FSM=IDLE, `level`=0, counters=0. The TXENABLE edge-detect register resets to 1, so a `TXENABLE` already high at reset release does not start a frame.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). No interrupt is produced.
- Start latency: in the cycle after the clock edge that samples the rising edge, `STATUS`=1 and `sinal`=`HIGH_LVL`.
- Frame length from the first non-idle cycle to the first idle cycle:
  - (8+16+1)×`BIT_LEN` = 800 clocks with the macro;
  - (16+1)×`BIT_LEN` = 544 clocks without it.
- Level changes occur only at cell offsets 0 and `BIT_LEN/2`. Edge-to-edge spacing is exactly 16 or 32 clocks.

## Configuration
- `MODULADOR_PREAMBLE_EN`:
  - Defined: the PRE state exists and `PREAMBLE` is transmitted before the payload; frame = 25 cells.
  - Undefined: no PRE state; DATA follows IDLE directly; frame = 17 cells; `PREAMBLE` is unused.

## Test plan
- Reset with `TXENABLE`=1, then release: `sinal`=8'h80 and `STATUS`=0 indefinitely. Pulse `TXENABLE` 0→1: frame starts one cycle later.
- `DATA_BYTE_0`=8'h01, `DATA_BYTE_1`=8'h80, no macro:
  - edges at offsets 0, 32, 48, 64, … ;
  - the bit-0 cell has no mid edge;
  - the bit-15 cell has no mid edge;
  - `STATUS` falls after 544 cycles;
  - `INTFLAG`=1.
- With the macro, `PREAMBLE`=8'hB4, payload 16'h0000:
  - the first 8 cells decode to 0,0,1,0,1,1,0,1;
  - then 16 cells each with a mid edge at +16;
  - frame = 800 cycles.
- `INTMASK`=0 at completion: `int_tx_host`=0 while `INTFLAG`=1. Raise `INTMASK`: `int_tx_host`=1 one cycle later. Assert `int_clr` and frame-done in the same cycle: `INTFLAG` stays 1.
- Drop `TXENABLE` at cycle 100 of a frame: `sinal`=8'h80 and `STATUS`=0 on the next cycle, `INTFLAG` stays 0. A new rising edge gives a full, correct frame.
- Assert `reset` mid-DATA: `sinal`=8'h80 with no clock edge. All flags 0.
